// File: rtl/params_pkg.sv
// Shared widths and types for the scoreboard hazard unit.
// The instruction descriptor and the per-register scoreboard entry live here.
package params_pkg;

  localparam int MAX_LAT       = 5;
  localparam int LAT_WIDTH     = $clog2(MAX_LAT + 1);
  localparam int PKG_NUM_REGS  = 32;
  localparam int PKG_REG_WIDTH = $clog2(PKG_NUM_REGS);

  typedef struct packed {
    logic [PKG_REG_WIDTH-1:0] rs1;
    logic [PKG_REG_WIDTH-1:0] rs2;
    logic                     rs1_needed;
    logic                     rs2_needed;
    logic [PKG_REG_WIDTH-1:0] rd;
    logic                     rd_valid;
    logic [LAT_WIDTH-1:0]     lat;
    logic                     is_branch;
    logic                     is_instr_mem;
  } hazard_ctrl_t;

  // cnt == 0 while pending marks a variable-latency (memory) writer.
  typedef struct packed {
    logic                 pending;
    logic [LAT_WIDTH-1:0] cnt;
  } sb_entry_t;

endpackage

// File: rtl/scoreboard_entry.sv
// One architectural register's pending bit and writeback countdown.
// cnt == 1 is the writeback cycle; pending drops at the edge closing it.
module scoreboard_entry
  import params_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 freeze_i,
  input  logic                 set_i,
  input  logic [LAT_WIDTH-1:0] set_cnt_i,
  input  logic                 mem_clr_i,
  output sb_entry_t            entry_o
);

  sb_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (!freeze_i && entry_q.cnt != '0) begin
      entry_d.cnt = entry_q.cnt - 1'b1;
      if (entry_q.cnt == LAT_WIDTH'(1)) entry_d.pending = 1'b0;
    end
    if (mem_clr_i) entry_d.pending = 1'b0;
    if (set_i) begin
      entry_d.pending = 1'b1;
      entry_d.cnt     = set_cnt_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) entry_q <= '0;
    else         entry_q <= entry_d;
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Decode-side scoreboard: tracks in-flight writers per register, reserves the
// fixed-latency writeback port and counts outstanding memory ops.
module scoreboard_hazard_unit
  import params_pkg::*;
#(
  parameter int NUM_REGS        = PKG_NUM_REGS,
  parameter int REGISTER_WIDTH  = $clog2(NUM_REGS),
  parameter int MEM_OUTSTANDING = 1,
  parameter int IN_ORDER_BRANCH = 0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 dec_valid_i,
  input  hazard_ctrl_t                         hazard_signals_i,
  input  logic                                 mem_busy_i,
  input  logic                                 mem_wb_valid_i,
  input  logic [REGISTER_WIDTH-1:0]            mem_wb_reg_i,
  output logic                                 stall_mem_o,
  output logic                                 stall_alu_o,
  output logic                                 stall_decode_o,
  output logic                                 stall_fetch_o,
  output logic                                 stall_ex_o,
  output logic                                 alu_bubble_o,
  output logic                                 issue_o,
  output logic [NUM_REGS-1:0]                  sb_busy_o,
  output logic [$clog2(MEM_OUTSTANDING+1)-1:0] mem_inflight_o
);

  localparam int MEM_CNT_W = $clog2(MEM_OUTSTANDING + 1);

  hazard_ctrl_t         hc;
  sb_entry_t            entry [NUM_REGS];
  logic [NUM_REGS-1:0]  sb_busy, mem_pend;
  logic [MAX_LAT:1]     resv_q, resv_d;
  logic [MEM_CNT_W-1:0] mem_inflight_q, mem_inflight_d, inflight_eff;
  logic [LAT_WIDTH-1:0] set_cnt;
  logic is_fixed_wr, is_mem_wr, raw1, raw2, waw, port_hz, mem_hz, br_hz;
  logic hazard, stall_decode, issue, fixed_set, mem_set, mem_issue, mem_wb_ack;

  assign hc       = hazard_signals_i;
  assign entry[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    scoreboard_entry u_entry (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .freeze_i  (mem_busy_i),
      .set_i     ((fixed_set || mem_set) && hc.rd == PKG_REG_WIDTH'(r)),
      .set_cnt_i (set_cnt),
      .mem_clr_i (mem_wb_valid_i && mem_wb_reg_i == REGISTER_WIDTH'(r) && mem_pend[r]),
      .entry_o   (entry[r])
    );
  end

  always_comb begin
    sb_busy  = '0;
    mem_pend = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      sb_busy[r]  = entry[r].pending;
      mem_pend[r] = entry[r].pending && entry[r].cnt == '0;
    end
  end

  always_comb begin
    is_fixed_wr = hc.rd_valid && hc.rd != '0 && !hc.is_instr_mem;
    is_mem_wr   = hc.rd_valid && hc.rd != '0 && hc.is_instr_mem;
    raw1        = hc.rs1_needed && hc.rs1 != '0 && sb_busy[hc.rs1];
    raw2        = hc.rs2_needed && hc.rs2 != '0 && sb_busy[hc.rs2];
    waw         = hc.rd_valid && hc.rd != '0 && sb_busy[hc.rd];
    port_hz     = 1'b0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (hc.lat == LAT_WIDTH'(k)) port_hz = resv_q[k];
    end
    port_hz = port_hz && is_fixed_wr;
    // A writeback to x0 retires a memory op that has no destination register.
    mem_wb_ack   = mem_wb_valid_i && mem_inflight_q != '0 &&
                   (mem_wb_reg_i == '0 || mem_pend[mem_wb_reg_i]);
    inflight_eff = mem_inflight_q - MEM_CNT_W'(mem_wb_ack);
    mem_hz       = hc.is_instr_mem && inflight_eff == MEM_CNT_W'(MEM_OUTSTANDING);
    br_hz        = (IN_ORDER_BRANCH != 0) && hc.is_branch &&
                   (|sb_busy || mem_inflight_q != '0);
    hazard       = raw1 || raw2 || waw || port_hz || mem_hz || br_hz;
    stall_decode = mem_busy_i || (dec_valid_i && hazard);
    issue        = dec_valid_i && !stall_decode;
    fixed_set    = issue && is_fixed_wr;
    mem_set      = issue && is_mem_wr;
    mem_issue    = issue && hc.is_instr_mem;
    set_cnt      = fixed_set ? hc.lat : '0;
  end

  // resv[k]: a fixed op writes back k cycles from now; a new lat-L op lands in
  // slot L-1 after this edge because the shift applies in the same cycle.
  always_comb begin
    resv_d = resv_q;
    if (!mem_busy_i) resv_d = {1'b0, resv_q[MAX_LAT:2]};
    if (fixed_set) begin
      for (int k = 2; k <= MAX_LAT; k++) begin
        if (hc.lat == LAT_WIDTH'(k)) resv_d[k-1] = 1'b1;
      end
    end
    mem_inflight_d = mem_inflight_q;
    if (mem_issue && !mem_wb_ack)      mem_inflight_d = mem_inflight_q + 1'b1;
    else if (!mem_issue && mem_wb_ack) mem_inflight_d = mem_inflight_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resv_q         <= '0;
      mem_inflight_q <= '0;
    end else begin
      resv_q         <= resv_d;
      mem_inflight_q <= mem_inflight_d;
    end
  end

  assign stall_mem_o    = mem_busy_i;
  assign stall_alu_o    = mem_busy_i;
  assign stall_ex_o     = 1'b0;
  assign stall_decode_o = stall_decode;
  assign stall_fetch_o  = stall_decode;
  assign alu_bubble_o   = dec_valid_i && br_hz;
  assign issue_o        = issue;
  assign sb_busy_o      = sb_busy;
  assign mem_inflight_o = mem_inflight_q;

  a_fixed_lat : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (dec_valid_i && hc.rd_valid && !hc.is_instr_mem) |->
      (hc.lat != '0 && hc.lat <= LAT_WIDTH'(MAX_LAT)));

  a_mem_wb_pending : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_wb_valid_i && mem_wb_reg_i != '0) |-> mem_pend[mem_wb_reg_i]);

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: two instances (in-order branch off/on)
// share stimulus; per-cycle expectations are queued and compared at negedge.
module tb_scoreboard_hazard_unit;
  import params_pkg::*;

  typedef struct {
    string       tag;
    logic        issue, stall, mb, io_stall, io_bubble, io_issue, infl;
    logic [31:0] busy;
  } exp_t;

  logic clk, rst_ni, rst_next, dec_valid, mem_busy, wb_valid;
  logic [4:0]   wb_reg;
  hazard_ctrl_t hc_in;

  logic s_mem, s_alu, s_dec, s_fetch, s_ex, bubble, issue, infl;
  logic [31:0] busy;
  logic i_mem, i_alu, i_dec, i_fetch, i_ex, i_bubble, i_issue, i_infl;
  logic [31:0] i_busy;

  exp_t exp_q[$];
  exp_t cur;
  int n_checks = 0;
  int n_errors = 0;
  int cyc_n = 0;

  scoreboard_hazard_unit #(.MEM_OUTSTANDING(1), .IN_ORDER_BRANCH(0)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .dec_valid_i(dec_valid), .hazard_signals_i(hc_in),
    .mem_busy_i(mem_busy), .mem_wb_valid_i(wb_valid), .mem_wb_reg_i(wb_reg),
    .stall_mem_o(s_mem), .stall_alu_o(s_alu), .stall_decode_o(s_dec),
    .stall_fetch_o(s_fetch), .stall_ex_o(s_ex), .alu_bubble_o(bubble),
    .issue_o(issue), .sb_busy_o(busy), .mem_inflight_o(infl));

  scoreboard_hazard_unit #(.MEM_OUTSTANDING(1), .IN_ORDER_BRANCH(1)) dut_io (
    .clk_i(clk), .rst_ni(rst_ni), .dec_valid_i(dec_valid), .hazard_signals_i(hc_in),
    .mem_busy_i(mem_busy), .mem_wb_valid_i(wb_valid), .mem_wb_reg_i(wb_reg),
    .stall_mem_o(i_mem), .stall_alu_o(i_alu), .stall_decode_o(i_dec),
    .stall_fetch_o(i_fetch), .stall_ex_o(i_ex), .alu_bubble_o(i_bubble),
    .issue_o(i_issue), .sb_busy_o(i_busy), .mem_inflight_o(i_infl));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic hazard_ctrl_t op(input logic [4:0] rd, input logic rdv,
      input logic [4:0] rs1, input logic n1, input logic [4:0] rs2, input logic n2,
      input logic [2:0] lat, input logic br, input logic mem);
    hazard_ctrl_t h;
    h.rd = rd; h.rd_valid = rdv; h.rs1 = rs1; h.rs1_needed = n1;
    h.rs2 = rs2; h.rs2_needed = n2; h.lat = lat; h.is_branch = br; h.is_instr_mem = mem;
    return h;
  endfunction

  function automatic hazard_ctrl_t nop();          return '0;                                endfunction
  function automatic hazard_ctrl_t alu(input logic [4:0] rd, input logic [2:0] l);
    return op(rd, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, l, 1'b0, 1'b0);
  endfunction
  function automatic hazard_ctrl_t dep(input logic [4:0] rd, input logic [4:0] s, input logic [2:0] l);
    return op(rd, 1'b1, s, 1'b1, 5'd0, 1'b0, l, 1'b0, 1'b0);
  endfunction
  function automatic hazard_ctrl_t dep2(input logic [4:0] rd, input logic [4:0] s, input logic [2:0] l);
    return op(rd, 1'b1, 5'd0, 1'b0, s, 1'b1, l, 1'b0, 1'b0);
  endfunction
  function automatic hazard_ctrl_t ld(input logic [4:0] rd);
    return op(rd, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1);
  endfunction
  function automatic hazard_ctrl_t br();
    return op(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b0);
  endfunction
  function automatic logic [31:0] b(input int r); return 32'd1 << r; endfunction

  task automatic cyc_br(input string tag, input logic v, input hazard_ctrl_t hc,
      input logic mb, input logic wbv, input logic [4:0] wbr,
      input logic e_issue, input logic e_stall, input logic [31:0] e_busy, input logic e_infl,
      input logic e_io_stall, input logic e_io_bubble);
    exp_t e;
    @(posedge clk); #1;
    rst_ni = rst_next; dec_valid = v; hc_in = hc; mem_busy = mb; wb_valid = wbv; wb_reg = wbr;
    e.tag = $sformatf("%s@%0d", tag, cyc_n);
    e.issue = e_issue; e.stall = e_stall; e.mb = mb; e.busy = e_busy; e.infl = e_infl;
    e.io_stall = e_io_stall; e.io_bubble = e_io_bubble; e.io_issue = v && !e_io_stall;
    exp_q.push_back(e);
    cyc_n++;
  endtask

  task automatic cyc(input string tag, input logic v, input hazard_ctrl_t hc,
      input logic mb, input logic wbv, input logic [4:0] wbr,
      input logic e_issue, input logic e_stall, input logic [31:0] e_busy, input logic e_infl);
    cyc_br(tag, v, hc, mb, wbv, wbr, e_issue, e_stall, e_busy, e_infl, e_stall, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      check({cur.tag, ".issue"},    issue,   cur.issue);
      check({cur.tag, ".stall_dec"}, s_dec,  cur.stall);
      check({cur.tag, ".stall_fet"}, s_fetch, cur.stall);
      check({cur.tag, ".stall_alu"}, s_alu,  cur.mb);
      check({cur.tag, ".stall_mem"}, s_mem,  cur.mb);
      check({cur.tag, ".stall_ex"},  s_ex,   1'b0);
      check({cur.tag, ".bubble"},    bubble, 1'b0);
      check({cur.tag, ".sb_busy"},   busy,   cur.busy);
      check({cur.tag, ".inflight"},  infl,   cur.infl);
      check({cur.tag, ".io_issue"},  i_issue, cur.io_issue);
      check({cur.tag, ".io_stall"},  i_dec,  cur.io_stall);
      check({cur.tag, ".io_fetch"},  i_fetch, cur.io_stall);
      check({cur.tag, ".io_bubble"}, i_bubble, cur.io_bubble);
      check({cur.tag, ".io_alu"},    i_alu,  cur.mb);
      check({cur.tag, ".io_mem"},    i_mem,  cur.mb);
      check({cur.tag, ".io_ex"},     i_ex,   1'b0);
      check({cur.tag, ".io_busy"},   i_busy, cur.busy);
      check({cur.tag, ".io_infl"},   i_infl, cur.infl);
    end
  end

  initial begin
    rst_ni = 1'b0; rst_next = 1'b1; dec_valid = 1'b0; hc_in = '0;
    mem_busy = 1'b0; wb_valid = 1'b0; wb_reg = '0;
    repeat (3) @(posedge clk);

    cyc("reset", 0, nop(), 0, 0, 0, 0, 0, 0, 0);

    // MUL x5 lat5 then dependent ADD x6 <- x5
    cyc("t1_mul", 1, alu(5, 5), 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("t1_raw", 1, dep(6, 5, 1), 0, 0, 0, 0, 1, b(5), 0);
    cyc("t1_iss", 1, dep(6, 5, 1), 0, 0, 0, 1, 0, 0, 0);
    cyc("t1_wb",  0, nop(), 0, 0, 0, 0, 0, b(6), 0);
    cyc("t1_idl", 0, nop(), 0, 0, 0, 0, 0, 0, 0);

    // writeback port conflict: MUL lat5 at t0, ADD lat1 at t4
    cyc("t2_mul", 1, alu(5, 5), 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t2_idl", 0, nop(), 0, 0, 0, 0, 0, b(5), 0);
    cyc("t2_port", 1, alu(7, 1), 0, 0, 0, 0, 1, b(5), 0);
    cyc("t2_iss",  1, alu(7, 1), 0, 0, 0, 1, 0, b(5), 0);
    cyc("t2_wb",   0, nop(), 0, 0, 0, 0, 0, b(7), 0);
    cyc("t2_idl",  0, nop(), 0, 0, 0, 0, 0, 0, 0);

    // two loads with one outstanding slot
    cyc("t3_ld3",  1, ld(3), 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc("t3_full", 1, ld(4), 0, 0, 0, 0, 1, b(3), 1);
    cyc("t3_swap", 1, ld(4), 0, 1, 3, 1, 0, b(3), 1);
    cyc("t3_hold", 0, nop(), 0, 0, 0, 0, 0, b(4), 1);
    cyc("t3_wb4",  0, nop(), 0, 1, 4, 0, 0, b(4), 1);
    cyc("t3_idl",  0, nop(), 0, 0, 0, 0, 0, 0, 0);

    // freeze three cycles during a lat-2 op
    cyc("t4_op", 1, alu(8, 2), 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t4_frz", 1, dep2(9, 8, 1), 1, 0, 0, 0, 1, b(8), 0);
    for (int i = 0; i < 2; i++) cyc("t4_raw", 1, dep2(9, 8, 1), 0, 0, 0, 0, 1, b(8), 0);
    cyc("t4_iss", 1, dep2(9, 8, 1), 0, 0, 0, 1, 0, 0, 0);
    cyc("t4_wb",  0, nop(), 0, 0, 0, 0, 0, b(9), 0);
    cyc("t4_idl", 0, nop(), 0, 0, 0, 0, 0, 0, 0);

    // branch behind an ALU op: serialised only on the in-order instance
    cyc("t5_add", 1, alu(10, 2), 0, 0, 0, 1, 0, 0, 0);
    cyc_br("t5_br", 1, br(), 0, 0, 0, 1, 0, b(10), 0, 1, 1);
    cyc_br("t5_br", 1, br(), 0, 0, 0, 1, 0, b(10), 0, 1, 1);
    cyc_br("t5_br", 1, br(), 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // reset while three ops are pending
    cyc("t6_mul", 1, alu(5, 5), 0, 0, 0, 1, 0, 0, 0);
    cyc("t6_ld",  1, ld(3), 0, 0, 0, 1, 0, b(5), 0);
    cyc("t6_add", 1, alu(7, 2), 0, 0, 0, 1, 0, b(5) | b(3), 1);
    rst_next = 1'b0;
    cyc("t6_rst", 0, nop(), 0, 0, 0, 0, 0, b(5) | b(3) | b(7), 1);
    rst_next = 1'b1;
    cyc("t6_dep", 1, dep(6, 5, 1), 0, 0, 0, 1, 0, 0, 0);
    cyc("t6_wb",  0, nop(), 0, 0, 0, 0, 0, b(6), 0);
    cyc("t6_idl", 0, nop(), 0, 0, 0, 0, 0, 0, 0);

    // WAW on x11
    cyc("t7_add", 1, alu(11, 3), 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t7_waw", 1, alu(11, 1), 0, 0, 0, 0, 1, b(11), 0);
    cyc("t7_iss", 1, alu(11, 1), 0, 0, 0, 1, 0, 0, 0);
    cyc("t7_wb",  0, nop(), 0, 0, 0, 0, 0, b(11), 0);
    cyc("t7_idl", 0, nop(), 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    check("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scoreboard_hazard_unit.md
# scoreboard_hazard_unit

Stateful, parametrised successor to the decode-stage hazard unit: a per-register scoreboard with countdown timers that allows fixed-latency EX operations of differing latency to complete out of order. It sits beside decode and issues one instruction per cycle when no hazard exists. It detects RAW, WAW, writeback-port and memory-outstanding hazards. Branch serialisation is a mode parameter rather than hardwired.

## Interface
- `NUM_REGS`, 32: architectural registers; register 0 is never tracked.
- `REGISTER_WIDTH`, `$clog2(NUM_REGS)`: register index width.
- `MAX_LAT`, 5: longest fixed EX latency in cycles (ALU=1 … MUL=5).
- `LAT_WIDTH`, `$clog2(MAX_LAT+1)`: latency/counter width.
- `MEM_OUTSTANDING`, 1: maximum in-flight memory ops.
- `IN_ORDER_BRANCH`, 0: 1 = branch waits until nothing is in flight.
- `clk_i`  in  1  clock; one clock domain.
- `rst_ni`  in  1  synchronous, active-low reset.
- `dec_valid_i`  in  1  decode holds a valid instruction.
- `hazard_signals_i`  in  `hazard_ctrl_t`  rs1/rs2, rs1_needed/rs2_needed, rd, rd_valid, lat, is_branch, is_instr_mem.
- `mem_busy_i`  in  1  memory stage busy; freezes the ALU pipeline.
- `mem_wb_valid_i`  in  1  memory result is written this cycle.
- `mem_wb_reg_i`  in  REGISTER_WIDTH  destination of that memory write.
- `stall_mem_o`, `stall_alu_o`, `stall_decode_o`, `stall_fetch_o`, `stall_ex_o`  out  1 each  stall controls.
- `alu_bubble_o`  out  1  insert bubble into ALU.
- `issue_o`  out  1  decode instruction issues this cycle.
- `sb_busy_o`  out  NUM_REGS  pending bit per register.
- `mem_inflight_o`  out  `$clog2(MEM_OUTSTANDING+1)`  outstanding memory ops.

## Operation
- Per-register entry: `pending` plus `cnt` (LAT_WIDTH). `cnt=0` while pending means a variable-latency (memory) writer.
- WB reservation vector `resv[MAX_LAT:1]`. `resv[k]` means a fixed op writes back k cycles from now.
- `issue_o = dec_valid_i & ~stall_decode_o`.
- `stall_mem_o = stall_alu_o = mem_busy_i`. `stall_ex_o = 0`. `stall_fetch_o = stall_decode_o`.
- `stall_decode_o` asserts when any of the following holds:
  - mem_busy_i;
  - RAW: rsN_needed, rsN≠0 and sb_busy[rsN];
  - WAW: rd_valid, rd≠0 and sb_busy[rd];
  - fixed op with resv[lat]=1 (writeback-port conflict);
  - is_instr_mem and mem_inflight=MEM_OUTSTANDING;
  - IN_ORDER_BRANCH=1, is_branch and (any sb_busy or mem_inflight≠0). This case also asserts `alu_bubble_o`.
- Hazard checks are qualified by dec_valid_i.
- Fixed issue with rd≠0: pending←1, cnt←lat, resv[lat]←1.
- Memory issue: pending←1, cnt←0, mem_inflight+1.
- Legal `lat` is 1..MAX_LAT. `lat=0` on a fixed op is an assertion failure.
- Each unfrozen cycle (~mem_busy_i): every cnt>0 decrements and resv shifts down one.
- An entry with cnt=1 writes back this cycle; pending clears at the closing edge.
- A frozen cycle holds all cnt and resv.
- mem_wb_valid_i clears pending of mem_wb_reg_i and decrements mem_inflight. This path is not frozen.
- Simultaneous mem issue and mem_wb in one cycle: mem_inflight unchanged.
- mem_wb to a register not memory-pending is ignored; an assertion flags it.
- No bypass: a consumer issues no earlier than the cycle after its producer's writeback.

## Timing
- Reset (rst_ni=0 at edge): all pending, cnt and resv cleared; mem_inflight=0. This applies mid-operation too; in-flight ops are forgotten.
- After reset with dec_valid_i=0, every output is 0.
- Stall and issue outputs are combinational from state and current inputs; state updates on the rising clk_i.
- Fixed op issued in cycle t with latency L, no freeze: writes back in cycle t+L; a dependent issues in t+L+1.
- Each frozen cycle delays both points by one.
- Issue of X and writeback clear of X in the same cycle cannot occur, because WAW stalls the issue.

## Structure
- `params_pkg` holds:
  - `MAX_LAT`;
  - `hazard_ctrl_t`, extended with rd, rd_valid and lat[LAT_WIDTH-1:0];
  - `sb_entry_t {pending, cnt}`.
- Sub-module `scoreboard_entry`: one register's pending bit and countdown, instantiated via generate for registers 1..NUM_REGS-1.
- Top level holds resv, mem counter, hazard compare and stall priority.

## Test plan
- Issue MUL x5 (lat 5) at t=0, then ADD x6←x5 → stall t=1..5, issue t=6; sb_busy[5] falls after the t=5 edge.
- MUL x5 (lat 5) at t=0, ADD x7 (lat 1) at t=4 → both write back at t=5, so the ADD stalls one cycle and issues at t=5.
- Load x3, then load x4 with MEM_OUTSTANDING=1 → second stalls until mem_wb_valid_i with reg 3; simultaneous wb and new issue leaves mem_inflight=1.
- mem_busy_i high 3 cycles during a lat-2 op → writeback delayed 3 cycles; stall_alu_o and stall_decode_o high throughout.
- IN_ORDER_BRANCH=1, branch with ADD in flight → stall_decode_o=1 and alu_bubble_o=1 until sb_busy=0. With IN_ORDER_BRANCH=0 and no RAW → branch issues immediately.
- rst_ni low while three ops are pending → next cycle sb_busy=0, mem_inflight=0, a dependent instruction issues.
